dsi_lanes_distributor: RTL and testbench
========================================

DSI_LANES_DISTRIBUTOR -- requirements
Module: dsi_lanes_distributor

Interface
REQ-001 SHALL have parameter TRAIL_CYCLES, default 8, meaning HS trail cycles held after the last byte (1..255).
REQ-002 SHALL have parameter PREP_TIMEOUT, default 255, meaning max cycles waiting for lanes_ready before abort (1..65535).
REQ-003 clk  in  1  system clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 iface_write_data  in  32  packet word; byte i goes to lane i.
REQ-006 iface_write_strb  in  4  byte valid mask; legal values 4'b0001/0011/0111/1111.
REQ-007 iface_write_rqst  in  1  upstream word valid.
REQ-008 iface_last_word  in  1  word is last of HS burst.
REQ-009 iface_data_rqst  out  1  distributor can accept a word this cycle.
REQ-010 lanes_hs_rqst  out  1  request HS entry on all lanes.
REQ-011 lanes_ready  in  1  all lanes in HS, accepting bytes.
REQ-012 lane_data  out  32  byte per lane, lane i = bits [8i+7:8i].
REQ-013 lane_valid  out  4  per-lane byte valid.
REQ-014 err_underflow, err_strb, err_timeout  out  1 each  sticky error flags.
REQ-015 err_clear  in  1  clears all sticky errors.

Function
REQ-016 Word transfer SHALL occur on cycles with iface_write_rqst && iface_data_rqst; no combinational path from iface_write_rqst to iface_data_rqst.
REQ-017 Input SHALL be a 2-entry FIFO (data, strb, last); iface_data_rqst = FIFO not full, any state except WAIT_STOP.
REQ-018 FSM states: IDLE, HS_PREP, ACTIVE, TRAIL, WAIT_STOP.
REQ-019 IDLE -> HS_PREP when FIFO non-empty; lanes_hs_rqst asserted from HS_PREP through TRAIL.
REQ-020 HS_PREP -> ACTIVE when lanes_ready=1; -> WAIT_STOP with err_timeout set when prep counter reaches PREP_TIMEOUT; FIFO flushed on timeout.
REQ-021 ACTIVE: one FIFO word popped per cycle; registered output, lane_data/lane_valid valid one cycle after pop; lane_valid = popped strb.
REQ-022 ACTIVE with FIFO empty and last word not yet sent: lane_valid=0, err_underflow set once per burst, remain ACTIVE.
REQ-023 Popping a word with last=1 SHALL move ACTIVE -> TRAIL; trail counter loaded with TRAIL_CYCLES.
REQ-024 TRAIL: lane_valid=0, lane_data=0; counter decrements; at 0 -> WAIT_STOP, lanes_hs_rqst deasserted.
REQ-025 WAIT_STOP -> IDLE when lanes_ready=0.
REQ-026 Non-contiguous or zero strb on accepted word: err_strb set, word forwarded with strb forced 4'b1111.
REQ-027 Partial strb on a non-last word: err_strb set, word forwarded unchanged.
REQ-028 lanes_ready dropping during ACTIVE/TRAIL: err_underflow set, FIFO flushed, -> WAIT_STOP.
REQ-029 err_clear and a simultaneous new error: set wins.
REQ-030 Words accepted during TRAIL SHALL stay queued and start a new burst via IDLE.

Reset
REQ-031 On rst_n low: state IDLE, FIFO empty, counters 0, lanes_hs_rqst=0, lane_data=0, lane_valid=0, iface_data_rqst=0, all err_* = 0.
REQ-032 Reset mid-burst SHALL drop lanes_hs_rqst asynchronously and discard queued words.
REQ-033 iface_data_rqst SHALL rise the first clk edge after reset release.

Structure
REQ-034 State enum, lane count (4) and legal strb constants SHALL live in the shared dsi package.
REQ-035 Input FIFO SHALL be sub-module dsi_skid_fifo2 (2-entry, 37-bit, flush input).

Verification
REQ-036 3 words 0x11223344, 0x55667788, 0xAABBCCDD (last, strb F), lanes_ready 2 cycles after request -> lane_data sequence matches, lane_valid=F x3, 8 trail cycles, return to IDLE.
REQ-037 Last word strb 4'b0011 data 0x0000BEEF -> lane_valid=0011 final cycle, lane_data[15:0]=0xBEEF, no error.
REQ-038 Upstream gap of 3 cycles mid-burst -> lane_valid=0 for 3 cycles, err_underflow=1, burst completes.
REQ-039 lanes_ready held 0, PREP_TIMEOUT=16 -> err_timeout at cycle 16, FIFO flushed, IDLE after lanes_ready low.
REQ-040 strb 4'b0101 -> err_strb=1, lane_valid=F; err_clear next cycle -> err_strb=0.
REQ-041 rst_n asserted mid-ACTIVE -> lanes_hs_rqst=0 same cycle, lane_valid=0, IDLE on release.

Source files
------------

// File: rtl/dsi_lanes_distributor_pkg.sv
// Shared DSI lane definitions: lane geometry, legal byte strobes, FSM states
// and the queued word layout used by the lanes distributor.
package dsi_lanes_distributor_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned DATA_W = LANES * LANE_W;

    localparam logic [LANES-1:0] STRB_1 = 4'b0001;
    localparam logic [LANES-1:0] STRB_2 = 4'b0011;
    localparam logic [LANES-1:0] STRB_3 = 4'b0111;
    localparam logic [LANES-1:0] STRB_4 = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HS_PREP,
        ST_ACTIVE,
        ST_TRAIL,
        ST_WAIT_STOP
    } dsi_state_e;

    typedef struct packed {
        logic              last;
        logic [LANES-1:0]  strb;
        logic [DATA_W-1:0] data;
    } dsi_word_t;

    localparam int unsigned WORD_W = $bits(dsi_word_t);

    // Only contiguous strobes starting at lane 0 are meaningful to the lanes
    function automatic logic strb_legal(input logic [LANES-1:0] s);
        return (s == STRB_1) || (s == STRB_2) || (s == STRB_3) || (s == STRB_4);
    endfunction

endpackage

// File: rtl/dsi_lanes_distributor_if.sv
// Upstream packet-word handshake between the packet builder and the distributor.
interface dsi_lanes_distributor_if;
    import dsi_lanes_distributor_pkg::*;

    logic [DATA_W-1:0] iface_write_data;
    logic [LANES-1:0]  iface_write_strb;
    logic              iface_write_rqst;
    logic              iface_last_word;
    logic              iface_data_rqst;

    modport master (
        output iface_write_data,
        output iface_write_strb,
        output iface_write_rqst,
        output iface_last_word,
        input  iface_data_rqst
    );

    modport slave (
        input  iface_write_data,
        input  iface_write_strb,
        input  iface_write_rqst,
        input  iface_last_word,
        output iface_data_rqst
    );

endinterface

// File: rtl/dsi_skid_fifo2.sv
// Two-entry FIFO with registered full/empty flags and a synchronous flush.
// Entry 0 is always the head, so pop_data needs no read pointer.
module dsi_skid_fifo2 #(
    parameter int unsigned W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_pop, do_push;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        cnt_d   = cnt_q;
        do_pop  = pop && (cnt_q != 2'd0);
        do_push = push && ((cnt_q != 2'd2) || do_pop);
        case ({do_push, do_pop})
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) ent0_d = push_data;
                else               ent1_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = push_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end
            end
            default: ;
        endcase
        if (flush) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pop_data = ent0_q;
    assign empty    = (cnt_q == 2'd0);
    assign full     = (cnt_q == 2'd2);

endmodule

// File: rtl/dsi_lanes_distributor.sv
// Spreads upstream packet words byte-per-lane across the DSI data lanes and
// sequences HS request, preparation timeout and trail for each burst.
module dsi_lanes_distributor
    import dsi_lanes_distributor_pkg::*;
#(
    parameter int unsigned TRAIL_CYCLES = 8,
    parameter int unsigned PREP_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dsi_lanes_distributor_if.slave   up,
    output logic                     lanes_hs_rqst,
    input  logic                     lanes_ready,
    output logic [DATA_W-1:0]        lane_data,
    output logic [LANES-1:0]         lane_valid,
    output logic                     err_underflow,
    output logic                     err_strb,
    output logic                     err_timeout,
    input  logic                     err_clear
);

    dsi_state_e        state_q, state_d;
    logic [15:0]       prep_cnt_q, prep_cnt_d;
    logic [7:0]        trail_cnt_q, trail_cnt_d;
    logic              hs_q, hs_d;
    logic [DATA_W-1:0] lane_data_q, lane_data_d;
    logic [LANES-1:0]  lane_valid_q, lane_valid_d;
    logic              err_und_q, err_und_d;
    logic              err_strb_q, err_strb_d;
    logic              err_tout_q, err_tout_d;
    logic              und_seen_q, und_seen_d;
    logic              rst_done_q;

    logic              data_rqst, accept;
    logic              strb_bad, strb_partial;
    logic              fifo_pop, fifo_flush, fifo_empty, fifo_full;
    logic              set_und, set_tout;
    dsi_word_t         push_word, head_word;

    // rst_done_q keeps the upstream handshake low until the first edge after reset
    assign data_rqst          = rst_done_q && !fifo_full && (state_q != ST_WAIT_STOP);
    assign up.iface_data_rqst = data_rqst;
    assign accept             = up.iface_write_rqst && data_rqst;

    always_comb begin
        strb_bad       = !strb_legal(up.iface_write_strb);
        strb_partial   = !strb_bad && (up.iface_write_strb != STRB_4) && !up.iface_last_word;
        push_word.last = up.iface_last_word;
        push_word.data = up.iface_write_data;
        push_word.strb = strb_bad ? STRB_4 : up.iface_write_strb;
    end

    dsi_skid_fifo2 #(.W(WORD_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (accept),
        .push_data (push_word),
        .pop       (fifo_pop),
        .pop_data  (head_word),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        state_d      = state_q;
        prep_cnt_d   = prep_cnt_q;
        trail_cnt_d  = trail_cnt_q;
        und_seen_d   = und_seen_q;
        lane_data_d  = '0;
        lane_valid_d = '0;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;
        set_und      = 1'b0;
        set_tout     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d    = ST_HS_PREP;
                    prep_cnt_d = '0;
                end
            end
            ST_HS_PREP: begin
                if (lanes_ready) begin
                    state_d    = ST_ACTIVE;
                    und_seen_d = 1'b0;
                end else begin
                    prep_cnt_d = prep_cnt_q + 16'd1;
                    if (prep_cnt_d == 16'(PREP_TIMEOUT)) begin
                        state_d    = ST_WAIT_STOP;
                        set_tout   = 1'b1;
                        fifo_flush = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!lanes_ready) begin
                    state_d    = ST_WAIT_STOP;
                    set_und    = 1'b1;
                    fifo_flush = 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    lane_data_d  = head_word.data;
                    lane_valid_d = head_word.strb;
                    if (head_word.last) begin
                        state_d     = ST_TRAIL;
                        trail_cnt_d = 8'(TRAIL_CYCLES);
                    end
                end else if (!und_seen_q) begin
                    set_und    = 1'b1;
                    und_seen_d = 1'b1;
                end
            end
            ST_TRAIL: begin
                // Counter runs TRAIL_CYCLES..0, giving TRAIL_CYCLES idle HS cycles after the last byte
                if (!lanes_ready) begin
                    state_d    = ST_WAIT_STOP;
                    set_und    = 1'b1;
                    fifo_flush = 1'b1;
                end else if (trail_cnt_q == 8'd0) begin
                    state_d = ST_WAIT_STOP;
                end else begin
                    trail_cnt_d = trail_cnt_q - 8'd1;
                end
            end
            ST_WAIT_STOP: begin
                if (!lanes_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        hs_d       = (state_d == ST_HS_PREP) || (state_d == ST_ACTIVE) || (state_d == ST_TRAIL);
        err_und_d  = (err_und_q  && !err_clear) || set_und;
        err_strb_d = (err_strb_q && !err_clear) || (accept && (strb_bad || strb_partial));
        err_tout_d = (err_tout_q && !err_clear) || set_tout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prep_cnt_q   <= '0;
            trail_cnt_q  <= '0;
            hs_q         <= 1'b0;
            lane_data_q  <= '0;
            lane_valid_q <= '0;
            err_und_q    <= 1'b0;
            err_strb_q   <= 1'b0;
            err_tout_q   <= 1'b0;
            und_seen_q   <= 1'b0;
            rst_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prep_cnt_q   <= prep_cnt_d;
            trail_cnt_q  <= trail_cnt_d;
            hs_q         <= hs_d;
            lane_data_q  <= lane_data_d;
            lane_valid_q <= lane_valid_d;
            err_und_q    <= err_und_d;
            err_strb_q   <= err_strb_d;
            err_tout_q   <= err_tout_d;
            und_seen_q   <= und_seen_d;
            rst_done_q   <= 1'b1;
        end
    end

    assign lanes_hs_rqst = hs_q;
    assign lane_data     = lane_data_q;
    assign lane_valid    = lane_valid_q;
    assign err_underflow = err_und_q;
    assign err_strb      = err_strb_q;
    assign err_timeout   = err_tout_q;

endmodule

// File: tb/tb_dsi_lanes_distributor.sv
// Directed vector bench for dsi_lanes_distributor: a per-cycle table of
// stimulus and expected outputs, plus a hand-written mid-burst reset sequence.
module tb_dsi_lanes_distributor;
    import dsi_lanes_distributor_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lanes_ready;
    logic        err_clear;
    logic        lanes_hs_rqst;
    logic [31:0] lane_data;
    logic [3:0]  lane_valid;
    logic        err_underflow, err_strb, err_timeout;

    always #5 clk = ~clk;

    dsi_lanes_distributor_if bus ();

    dsi_lanes_distributor #(
        .TRAIL_CYCLES (8),
        .PREP_TIMEOUT (16)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .up            (bus),
        .lanes_hs_rqst (lanes_hs_rqst),
        .lanes_ready   (lanes_ready),
        .lane_data     (lane_data),
        .lane_valid    (lane_valid),
        .err_underflow (err_underflow),
        .err_strb      (err_strb),
        .err_timeout   (err_timeout),
        .err_clear     (err_clear)
    );

    typedef struct {
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        ready;
        logic        clr;
        logic [31:0] e_data;
        logic [3:0]  e_valid;
        logic        e_hs;
        logic        e_drq;
        logic [2:0]  e_err;   // {underflow, strb, timeout}
    } vec_t;

    localparam logic [2:0] E0 = 3'b000;
    localparam logic [2:0] EU = 3'b100;
    localparam logic [2:0] ES = 3'b010;
    localparam logic [2:0] ET = 3'b001;
    localparam logic [3:0] F  = 4'b1111;

    vec_t        vecs[$];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    function automatic vec_t mk(input logic wr, input logic [31:0] wd, input logic [3:0] ws,
                                input logic wl, input logic rdy, input logic clr,
                                input logic [31:0] ed, input logic [3:0] ev, input logic eh,
                                input logic edr, input logic [2:0] ee);
        vec_t v;
        v.wr = wr; v.wdata = wd; v.wstrb = ws; v.wlast = wl; v.ready = rdy; v.clr = clr;
        v.e_data = ed; v.e_valid = ev; v.e_hs = eh; v.e_drq = edr; v.e_err = ee;
        return v;
    endfunction

    task automatic add(input logic wr, input logic [31:0] wd, input logic [3:0] ws,
                       input logic wl, input logic rdy, input logic clr,
                       input logic [31:0] ed, input logic [3:0] ev, input logic eh,
                       input logic edr, input logic [2:0] ee);
        vecs.push_back(mk(wr, wd, ws, wl, rdy, clr, ed, ev, eh, edr, ee));
    endtask

    task automatic nop(input int unsigned n, input logic rdy, input logic clr,
                       input logic eh, input logic edr, input logic [2:0] ee);
        for (int unsigned i = 0; i < n; i++) add(1'b0, '0, '0, 1'b0, rdy, clr, '0, '0, eh, edr, ee);
    endtask

    // Eight idle HS cycles after the last byte, one WAIT_STOP cycle, then back to IDLE.
    task automatic finish_burst(input logic [2:0] ee);
        nop(8, 1'b1, 1'b0, 1'b1, 1'b1, ee);
        nop(1, 1'b1, 1'b0, 1'b0, 1'b0, ee);
        nop(1, 1'b0, 1'b0, 1'b0, 1'b1, ee);
    endtask

    function automatic logic [40:0] outs();
        return {lane_data, lane_valid, lanes_hs_rqst, bus.iface_data_rqst,
                err_underflow, err_strb, err_timeout};
    endfunction

    task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got data=%h valid=%b hs=%b drq=%b err=%b, expected data=%h valid=%b hs=%b drq=%b err=%b",
                     name, act[40:9], act[8:5], act[4], act[3], act[2:0],
                     exp[40:9], exp[8:5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        bus.iface_write_rqst = v.wr;
        bus.iface_write_data = v.wdata;
        bus.iface_write_strb = v.wstrb;
        bus.iface_last_word  = v.wlast;
        lanes_ready          = v.ready;
        err_clear            = v.clr;
        @(posedge clk);
        #1;
        check(name, outs(), {v.e_data, v.e_valid, v.e_hs, v.e_drq, v.e_err});
    endtask

    initial begin
        bus.iface_write_rqst = 1'b0;
        bus.iface_write_data = '0;
        bus.iface_write_strb = '0;
        bus.iface_last_word  = 1'b0;
        lanes_ready          = 1'b0;
        err_clear            = 1'b0;

        // Three full words, lanes_ready two cycles after HS request
        add(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, E0);
        add(1'b1, 32'h11223344, F, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, E0);
        add(1'b1, 32'h55667788, F, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, E0);
        nop(1, 1'b0, 1'b0, 1'b1, 1'b0, E0);
        nop(1, 1'b1, 1'b0, 1'b1, 1'b0, E0);
        add(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h11223344, F, 1'b1, 1'b1, E0);
        add(1'b1, 32'hAABBCCDD, F, 1'b1, 1'b1, 1'b0, 32'h55667788, F, 1'b1, 1'b1, E0);
        add(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hAABBCCDD, F, 1'b1, 1'b1, E0);
        finish_burst(E0);

        // Single partial last word
        add(1'b1, 32'h0000BEEF, 4'b0011, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, E0);
        nop(2, 1'b1, 1'b0, 1'b1, 1'b1, E0);
        add(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0000BEEF, 4'b0011, 1'b1, 1'b1, E0);
        finish_burst(E0);

        // Upstream gap mid-burst
        add(1'b1, 32'hA0A0A0A0, F, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, E0);
        nop(2, 1'b1, 1'b0, 1'b1, 1'b1, E0);
        add(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hA0A0A0A0, F, 1'b1, 1'b1, E0);
        nop(2, 1'b1, 1'b0, 1'b1, 1'b1, EU);
        add(1'b1, 32'hB0B0B0B0, F, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, EU);
        add(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hB0B0B0B0, F, 1'b1, 1'b1, EU);
        finish_burst(EU);
        nop(1, 1'b0, 1'b1, 1'b0, 1'b1, E0);

        // Strobe errors: gap strobe forced to F, clear, partial non-last with clear (set wins)
        add(1'b1, 32'h01020304, 4'b0101, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, ES);
        nop(1, 1'b1, 1'b1, 1'b1, 1'b1, E0);
        add(1'b1, 32'h0000CAFE, 4'b0011, 1'b0, 1'b1, 1'b1, 32'h0, 4'h0, 1'b1, 1'b0, ES);
        add(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h01020304, F, 1'b1, 1'b1, ES);
        add(1'b1, 32'h00000099, 4'b0001, 1'b1, 1'b1, 1'b0, 32'h0000CAFE, 4'b0011, 1'b1, 1'b1, ES);
        add(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h00000099, 4'b0001, 1'b1, 1'b1, ES);
        finish_burst(ES);
        nop(1, 1'b0, 1'b1, 1'b0, 1'b1, E0);

        // lanes_ready drops in ACTIVE: flush, no new burst afterwards
        add(1'b1, 32'h5A5A5A5A, F, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, E0);
        add(1'b1, 32'h6B6B6B6B, F, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, E0);
        nop(1, 1'b1, 1'b0, 1'b1, 1'b0, E0);
        nop(1, 1'b0, 1'b0, 1'b0, 1'b0, EU);
        nop(2, 1'b0, 1'b0, 1'b0, 1'b1, EU);
        nop(1, 1'b0, 1'b1, 1'b0, 1'b1, E0);

        // Prep timeout with PREP_TIMEOUT=16: 16 HS_PREP cycles, then WAIT_STOP
        add(1'b1, 32'h00000077, F, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, E0);
        add(1'b1, 32'h00000088, F, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, E0);
        nop(15, 1'b0, 1'b0, 1'b1, 1'b0, E0);
        nop(1, 1'b0, 1'b0, 1'b0, 1'b0, ET);
        nop(3, 1'b0, 1'b0, 1'b0, 1'b1, ET);
        nop(1, 1'b0, 1'b1, 1'b0, 1'b1, E0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted mid-ACTIVE
        apply(mk(1'b1, 32'hC0C0C0C0, F, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, E0), "rst_push0");
        apply(mk(1'b1, 32'hD0D0D0D0, F, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, E0), "rst_push1");
        apply(mk(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, E0), "rst_active");
        apply(mk(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hC0C0C0C0, F, 1'b1, 1'b1, E0), "rst_pop");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", outs(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, E0), "rst_release");
        apply(mk(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, E0), "rst_discard0");
        apply(mk(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, E0), "rst_discard1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
